// File: rtl/crack_sched.sv
// Launches NCORES crack cores, takes the first valid key, aborts the losers,
// and round-robin shares a single ct_mem read port among the cores.
module crack_sched #(
  parameter int NCORES = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int KEY_W  = 24,
  parameter int RD_LAT = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  output logic                     rdy_o,
  output logic [KEY_W-1:0]         key_o,
  output logic                     key_valid_o,
  output logic [NCORES-1:0]        core_en_o,
  output logic [NCORES-1:0]        core_abort_o,
  input  logic [NCORES-1:0]        core_rdy_i,
  input  logic [NCORES*KEY_W-1:0]  core_key_i,
  input  logic [NCORES-1:0]        core_key_valid_i,
  input  logic [NCORES-1:0]        core_ct_req_i,
  input  logic [NCORES*ADDR_W-1:0] core_ct_addr_i,
  output logic [NCORES-1:0]        core_ct_gnt_o,
  output logic [NCORES-1:0]        core_ct_rvalid_o,
  output logic [DATA_W-1:0]        core_ct_rddata_o,
  output logic [ADDR_W-1:0]        ct_addr_o,
  input  logic [DATA_W-1:0]        ct_rddata_i
);

  localparam int PTR_W = $clog2(NCORES);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DRAIN} state_e;

  state_e              state_q;
  logic                rdy_q;
  logic                key_valid_q;
  logic [KEY_W-1:0]    key_q;
  logic [NCORES-1:0]   core_en_q;
  logic [NCORES-1:0]   core_abort_q;
  logic [NCORES-1:0]   started_q;
  logic [NCORES-1:0]   done_q;

  logic [NCORES-1:0]   started_d;
  logic [NCORES-1:0]   done_d;
  logic [NCORES-1:0]   finish;
  logic [NCORES-1:0]   win_vec;
  logic                win_any;
  logic [KEY_W-1:0]    win_key;

  logic [PTR_W-1:0]    rr_q;
  logic [ADDR_W-1:0]   ct_addr_q;
  logic [NCORES-1:0]   rv_pipe_q [RD_LAT];
  logic [NCORES-1:0]   gnt;
  logic                gnt_any;
  int                  gnt_idx;
  int                  idx;

  // A core counts as finished only once it has been seen busy in this run.
  always_comb begin
    started_d = started_q | ~core_rdy_i;
    finish    = core_rdy_i & started_q & ~done_q;
    done_d    = done_q | finish;
    win_vec   = finish & core_key_valid_i;
    win_any   = |win_vec;
    win_key   = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (win_vec[i]) win_key = core_key_i[i*KEY_W +: KEY_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rdy_q        <= 1'b1;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      core_en_q    <= '0;
      core_abort_q <= '0;
      started_q    <= '0;
      done_q       <= '0;
    end else begin
      core_en_q    <= '0;
      core_abort_q <= '0;
      case (state_q)
        IDLE: begin
          if (en_i) begin
            state_q     <= LAUNCH;
            rdy_q       <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            started_q   <= '0;
            done_q      <= '0;
          end
        end
        LAUNCH: begin
          if (&core_rdy_i) begin
            core_en_q <= '1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          started_q <= started_d;
          done_q    <= done_d;
          if (win_any) begin
            key_q        <= win_key;
            key_valid_q  <= 1'b1;
            core_abort_q <= ~done_d;
            state_q      <= DRAIN;
          end else if (&done_d) begin
            key_q       <= '0;
            key_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
            state_q     <= IDLE;
          end
        end
        DRAIN: begin
          if (&core_rdy_i) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant is combinational so a core can drop its request on the grant edge.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = 0;
    idx     = 0;
    for (int k = 0; k < NCORES; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NCORES) idx = idx - NCORES;
      if (!gnt_any && core_ct_req_i[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt_any = gnt_any & rst_ni;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      ct_addr_q <= '0;
      for (int s = 0; s < RD_LAT; s++) rv_pipe_q[s] <= '0;
    end else begin
      if (gnt_any) begin
        rr_q      <= PTR_W'((gnt_idx + 1) % NCORES);
        ct_addr_q <= core_ct_addr_i[gnt_idx*ADDR_W +: ADDR_W];
      end
      rv_pipe_q[0] <= gnt;
      for (int s = 1; s < RD_LAT; s++) rv_pipe_q[s] <= rv_pipe_q[s-1];
    end
  end

  assign rdy_o            = rdy_q;
  assign key_o            = key_q;
  assign key_valid_o      = key_valid_q;
  assign core_en_o        = core_en_q;
  assign core_abort_o     = core_abort_q;
  assign core_ct_gnt_o    = gnt;
  assign core_ct_rvalid_o = rv_pipe_q[RD_LAT-1];
  assign core_ct_rddata_o = ct_rddata_i;
  assign ct_addr_o        = ct_addr_q;

endmodule
